// File: rtl/bus_sink_if.sv
// Bundle of common-bus inputs and register/memory-write outputs for bus_sink.
// The master drives the bus and strobes; the slave (bus_sink) owns the registers.
interface bus_sink_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic [DATA_W-1:0] bus;
  logic [2:0]        dest;
  logic              ld;
  logic              inc_pc;
  logic              inc_dr;
  logic              clr_ac;
  logic              mem_ack;

  logic [ADDR_W-1:0] ar;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] dr;
  logic [DATA_W-1:0] ac;
  logic [DATA_W-1:0] ir;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              err;

  modport master (
    output bus, dest, ld, inc_pc, inc_dr, clr_ac, mem_ack,
    input  ar, pc, dr, ac, ir, mem_we, mem_addr, mem_wdata, busy, err
  );

  modport slave (
    input  bus, dest, ld, inc_pc, inc_dr, clr_ac, mem_ack,
    output ar, pc, dr, ac, ir, mem_we, mem_addr, mem_wdata, busy, err
  );
endinterface

// File: rtl/bus_sink.sv
// Common-bus register sink: captures the bus into AR/PC/DR/AC/IR and issues
// single outstanding memory writes through a two-state IDLE/WRITE handshake.
module bus_sink #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  bus_sink_if.slave  sif
);

  localparam int D_AR  = 1;
  localparam int D_PC  = 2;
  localparam int D_DR  = 3;
  localparam int D_AC  = 4;
  localparam int D_IR  = 5;
  localparam int D_MEM = 6;
  localparam int D_RSV = 7;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ar_reg, ar_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] dr_reg, dr_next;
  logic [DATA_W-1:0] ac_reg, ac_next;
  logic [DATA_W-1:0] ir_reg, ir_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic              err_reg, err_next;
  logic [7:0]        sel;

  // One-hot decode of the qualified destination.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sel
      assign sel[gi] = sif.ld && (sif.dest == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ar_reg        <= '0;
      pc_reg        <= '0;
      dr_reg        <= '0;
      ac_reg        <= '0;
      ir_reg        <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ar_reg        <= ar_next;
      pc_reg        <= pc_next;
      dr_reg        <= dr_next;
      ac_reg        <= ac_next;
      ir_reg        <= ir_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ar_next        = ar_reg;
    pc_next        = pc_reg;
    dr_next        = dr_reg;
    ac_next        = ac_reg;
    ir_next        = ir_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    err_next       = err_reg;

    // A load into a register overrides its own inc/clr in the same cycle.
    if (sel[D_AR]) ar_next = sif.bus[ADDR_W-1:0];

    if (sel[D_PC])       pc_next = sif.bus[ADDR_W-1:0];
    else if (sif.inc_pc) pc_next = pc_reg + 1'b1;

    if (sel[D_DR])       dr_next = sif.bus;
    else if (sif.inc_dr) dr_next = dr_reg + 1'b1;

    if (sel[D_AC])       ac_next = sif.bus;
    else if (sif.clr_ac) ac_next = '0;

    if (sel[D_IR]) ir_next = sif.bus;

    if (sel[D_RSV]) err_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (sel[D_MEM]) begin
          mem_addr_next  = ar_reg;
          mem_wdata_next = sif.bus;
          state_next     = WRITE;
        end
      end
      WRITE: begin
        // Only one write may be outstanding; a second request is dropped.
        if (sel[D_MEM]) err_next = 1'b1;
        if (sif.mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Decoded straight from the state flop so async reset drops the request at once.
  assign sif.mem_we    = (state_reg == WRITE);
  assign sif.busy      = (state_reg == WRITE);
  assign sif.ar        = ar_reg;
  assign sif.pc        = pc_reg;
  assign sif.dr        = dr_reg;
  assign sif.ac        = ac_reg;
  assign sif.ir        = ir_reg;
  assign sif.mem_addr  = mem_addr_reg;
  assign sif.mem_wdata = mem_wdata_reg;
  assign sif.err       = err_reg;

endmodule

// File: tb/tb_bus_sink.sv
// Directed bench for bus_sink: loads, wrap/priority, write handshake,
// protocol errors and asynchronous reset during a write.
module tb_bus_sink;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec  = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  bus_sink_if #(.DATA_W(8), .ADDR_W(5)) sif ();

  bus_sink #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    sif.bus     = '0;
    sif.dest    = '0;
    sif.ld      = 1'b0;
    sif.inc_pc  = 1'b0;
    sif.inc_dr  = 1'b0;
    sif.clr_ac  = 1'b0;
    sif.mem_ack = 1'b0;
  endtask

  task automatic load(input logic [2:0] d, input logic [7:0] v);
    sif.ld   = 1'b1;
    sif.dest = d;
    sif.bus  = v;
    tick();
    sif.ld   = 1'b0;
    sif.dest = 3'd0;
  endtask

  task automatic test_reset;
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    nvec++; if ({sif.ar, sif.pc} !== 10'h0) begin $display("FAIL reset_ar_pc: got %h required 0", {sif.ar, sif.pc}); nfail++; end
    nvec++; if ({sif.dr, sif.ac, sif.ir} !== 24'h0) begin $display("FAIL reset_dr_ac_ir: got %h required 0", {sif.dr, sif.ac, sif.ir}); nfail++; end
    nvec++; if ({sif.mem_addr, sif.mem_wdata} !== 13'h0) begin $display("FAIL reset_mem: got %h required 0", {sif.mem_addr, sif.mem_wdata}); nfail++; end
    nvec++; if ({sif.mem_we, sif.busy, sif.err} !== 3'b000) begin $display("FAIL reset_flags: got %b required 000", {sif.mem_we, sif.busy, sif.err}); nfail++; end
    $display("test_reset done");
  endtask

  task automatic test_first_capture;
    rst      = 1'b0;
    sif.ld   = 1'b1;
    sif.dest = 3'd1;
    sif.bus  = 8'h15;
    #1;
    nvec++; if (sif.ar !== 5'h00) begin $display("FAIL first_pre_edge: ar got %h required 00", sif.ar); nfail++; end
    tick();
    idle_in();
    nvec++; if (sif.ar !== 5'h15) begin $display("FAIL first_capture: ar got %h required 15", sif.ar); nfail++; end
    $display("test_first_capture ar=%h", sif.ar);
  endtask

  task automatic test_load_sweep;
    load(3'd1, 8'hE7);
    load(3'd2, 8'hE7);
    load(3'd3, 8'hE7);
    nvec++; if (sif.dr !== 8'hE7) begin $display("FAIL sweep_latency: dr got %h required e7", sif.dr); nfail++; end
    load(3'd4, 8'hE7);
    load(3'd5, 8'hE7);
    nvec++; if ({sif.ar, sif.pc} !== {5'h07, 5'h07}) begin $display("FAIL sweep_ar_pc: got %h/%h required 07/07", sif.ar, sif.pc); nfail++; end
    nvec++; if ({sif.dr, sif.ac, sif.ir} !== 24'hE7E7E7) begin $display("FAIL sweep_data: got %h required e7e7e7", {sif.dr, sif.ac, sif.ir}); nfail++; end
    nvec++; if (sif.err !== 1'b0) begin $display("FAIL sweep_err: got %b required 0", sif.err); nfail++; end
    load(3'd0, 8'h55);
    nvec++; if ({sif.ar, sif.pc, sif.dr, sif.ac, sif.ir, sif.mem_we, sif.err} !== {5'h07, 5'h07, 24'hE7E7E7, 2'b00})
      begin $display("FAIL dest_none: got %h required %h", {sif.ar, sif.pc, sif.dr, sif.ac, sif.ir, sif.mem_we, sif.err}, {5'h07, 5'h07, 24'hE7E7E7, 2'b00}); nfail++; end
    $display("test_load_sweep ar=%h pc=%h dr=%h ac=%h ir=%h", sif.ar, sif.pc, sif.dr, sif.ac, sif.ir);
  endtask

  task automatic test_wrap_priority;
    load(3'd2, 8'h1F);
    sif.inc_pc = 1'b1; tick(); sif.inc_pc = 1'b0;
    nvec++; if (sif.pc !== 5'h00) begin $display("FAIL pc_wrap: got %h required 00", sif.pc); nfail++; end
    load(3'd3, 8'hFF);
    sif.inc_dr = 1'b1; tick(); sif.inc_dr = 1'b0;
    nvec++; if (sif.dr !== 8'h00) begin $display("FAIL dr_wrap: got %h required 00", sif.dr); nfail++; end
    sif.inc_pc = 1'b1; load(3'd2, 8'h03); sif.inc_pc = 1'b0;
    nvec++; if (sif.pc !== 5'h03) begin $display("FAIL pc_ld_wins: got %h required 03", sif.pc); nfail++; end
    sif.inc_pc = 1'b1; load(3'd3, 8'h12); sif.inc_pc = 1'b0;
    nvec++; if ({sif.pc, sif.dr} !== {5'h04, 8'h12}) begin $display("FAIL inc_pc_ld_dr: got %h/%h required 04/12", sif.pc, sif.dr); nfail++; end
    sif.clr_ac = 1'b1; load(3'd4, 8'h40); sif.clr_ac = 1'b0;
    nvec++; if (sif.ac !== 8'h40) begin $display("FAIL ac_ld_wins: got %h required 40", sif.ac); nfail++; end
    sif.clr_ac = 1'b1; tick(); sif.clr_ac = 1'b0;
    nvec++; if (sif.ac !== 8'h00) begin $display("FAIL clr_ac: got %h required 00", sif.ac); nfail++; end
    sif.inc_dr = 1'b1; load(3'd5, 8'h3C); sif.inc_dr = 1'b0;
    nvec++; if ({sif.dr, sif.ir} !== 16'h133C) begin $display("FAIL inc_dr_ld_ir: got %h/%h required 13/3c", sif.dr, sif.ir); nfail++; end
    $display("test_wrap_priority pc=%h dr=%h ac=%h ir=%h", sif.pc, sif.dr, sif.ac, sif.ir);
  endtask

  task automatic test_write_handshake;
    load(3'd1, 8'h0A);
    load(3'd6, 8'h5C);
    sif.bus = 8'hAA;
    for (int c = 0; c < 3; c++) begin
      nvec++; if ({sif.mem_we, sif.busy} !== 2'b11) begin $display("FAIL wr_active_c%0d: we/busy got %b required 11", c, {sif.mem_we, sif.busy}); nfail++; end
      nvec++; if ({sif.mem_addr, sif.mem_wdata} !== {5'h0A, 8'h5C}) begin $display("FAIL wr_stable_c%0d: got %h/%h required 0a/5c", c, sif.mem_addr, sif.mem_wdata); nfail++; end
      if (c == 1) begin
        nvec++; if (sif.pc !== 5'h05) begin $display("FAIL wr_inc_pc: got %h required 05", sif.pc); nfail++; end
      end
      sif.inc_pc  = (c == 0);
      sif.mem_ack = (c == 2);
      tick();
    end
    sif.mem_ack = 1'b0;
    sif.inc_pc  = 1'b0;
    nvec++; if ({sif.mem_we, sif.busy} !== 2'b00) begin $display("FAIL wr_after_ack: we/busy got %b required 00", {sif.mem_we, sif.busy}); nfail++; end
    load(3'd6, 8'h21);
    nvec++; if ({sif.mem_we, sif.mem_wdata} !== {1'b1, 8'h21}) begin $display("FAIL wr_next_start: got %b/%h required 1/21", sif.mem_we, sif.mem_wdata); nfail++; end
    sif.mem_ack = 1'b1; tick(); sif.mem_ack = 1'b0;
    nvec++; if (sif.mem_we !== 1'b0) begin $display("FAIL wr_next_done: we got %b required 0", sif.mem_we); nfail++; end
    sif.mem_ack = 1'b1; tick(); sif.mem_ack = 1'b0;
    nvec++; if ({sif.mem_we, sif.busy, sif.err} !== 3'b000) begin $display("FAIL ack_idle: got %b required 000", {sif.mem_we, sif.busy, sif.err}); nfail++; end
    $display("test_write_handshake addr=%h wdata=%h", sif.mem_addr, sif.mem_wdata);
  endtask

  task automatic test_errors;
    load(3'd6, 8'h33);
    load(3'd6, 8'h99);
    nvec++; if (sif.err !== 1'b1) begin $display("FAIL err_mem_in_write: got %b required 1", sif.err); nfail++; end
    nvec++; if ({sif.mem_we, sif.mem_addr, sif.mem_wdata} !== {1'b1, 5'h0A, 8'h33}) begin $display("FAIL err_write_kept: got %b/%h/%h required 1/0a/33", sif.mem_we, sif.mem_addr, sif.mem_wdata); nfail++; end
    sif.mem_ack = 1'b1; tick(); sif.mem_ack = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    nvec++; if (sif.err !== 1'b0) begin $display("FAIL err_reset_clear: got %b required 0", sif.err); nfail++; end
    load(3'd4, 8'h5A);
    load(3'd7, 8'h77);
    nvec++; if (sif.err !== 1'b1) begin $display("FAIL err_dest_rsv: got %b required 1", sif.err); nfail++; end
    nvec++; if ({sif.ar, sif.pc, sif.dr, sif.ac, sif.ir, sif.mem_we} !== {10'h0, 8'h00, 8'h5A, 8'h00, 1'b0})
      begin $display("FAIL rsv_no_change: got %h required %h", {sif.ar, sif.pc, sif.dr, sif.ac, sif.ir, sif.mem_we}, {10'h0, 8'h00, 8'h5A, 8'h00, 1'b0}); nfail++; end
    for (int c = 0; c < 10; c++) begin
      tick();
      nvec++; if (sif.err !== 1'b1) begin $display("FAIL err_sticky_c%0d: got %b required 1", c, sif.err); nfail++; end
    end
    $display("test_errors err=%b", sif.err);
  endtask

  task automatic test_reset_mid_write;
    rst = 1'b1; tick(); rst = 1'b0;
    load(3'd1, 8'h0B);
    load(3'd6, 8'h44);
    nvec++; if (sif.mem_we !== 1'b1) begin $display("FAIL rmw_started: we got %b required 1", sif.mem_we); nfail++; end
    rst = 1'b1;
    #1;
    nvec++; if ({sif.mem_we, sif.busy} !== 2'b00) begin $display("FAIL rmw_async_drop: we/busy got %b required 00", {sif.mem_we, sif.busy}); nfail++; end
    nvec++; if ({sif.ar, sif.pc, sif.dr, sif.ac, sif.ir, sif.mem_addr, sif.mem_wdata} !== 47'h0)
      begin $display("FAIL rmw_regs_zero: got %h required 0", {sif.ar, sif.pc, sif.dr, sif.ac, sif.ir, sif.mem_addr, sif.mem_wdata}); nfail++; end
    tick();
    rst = 1'b0;
    sif.mem_ack = 1'b1; tick(); sif.mem_ack = 1'b0;
    nvec++; if ({sif.mem_we, sif.busy, sif.err} !== 3'b000) begin $display("FAIL rmw_after_release: got %b required 000", {sif.mem_we, sif.busy, sif.err}); nfail++; end
    tick();
    nvec++; if ({sif.mem_we, sif.mem_addr} !== 6'h0) begin $display("FAIL rmw_not_resumed: got %b/%h required 0/00", sif.mem_we, sif.mem_addr); nfail++; end
    $display("test_reset_mid_write we=%b err=%b", sif.mem_we, sif.err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_capture();
    test_load_sweep();
    test_wrap_priority();
    test_write_handshake();
    test_errors();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
